sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 5, SHALL set the SRAM controller cycle length in clocks, i.e. idle plus four phase states.
REQ-002 Parameter ADDR_W, default 18, SHALL set the word-address width.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req0 / req1  in  1  access request, held high until the matching ack.
REQ-006 we0 / we1  in  1  1 = write, 0 = read; qualified by req.
REQ-007 addr0 / addr1  in  ADDR_W  32-bit word address.
REQ-008 wdata0 / wdata1  in  32  write data.
REQ-009 ack0 / ack1  out  1  one-cycle completion pulse.
REQ-010 rdata  out  32  read data, shared by both requesters, valid in the ack cycle and held until the next ack.
REQ-011 mem_wren  out  1  drives the SRAM controller wren input.
REQ-012 mem_addr  out  ADDR_W  drives the SRAM controller starting_address input.
REQ-013 mem_wdata  out  32  drives the SRAM controller data_write input.
REQ-014 mem_rdata  in  32  driven from the SRAM controller data_read output.
REQ-015 busy  out  1  high while in ACCESS or DONE.
REQ-016 grant_id  out  1  index of the current or most recent grantee.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS and DONE; reset SHALL enter IDLE.
REQ-018 IDLE with any req high SHALL select a winner, latch its we/addr/wdata into mem_* and go to ACCESS on the next edge.
REQ-019 Arbitration SHALL be round-robin:
- with both req high, the requester not granted last wins;
- with a single req high, that requester wins.
REQ-020 The last_grant register SHALL update at each grant.
REQ-021 ACCESS SHALL last exactly 2*ACCESS_CYCLES clocks, counted by a down-counter loaded at grant.
REQ-022 For a write, mem_wren SHALL be high for the first ACCESS_CYCLES clocks of ACCESS and low for the remainder. This guarantees exactly one controller write sample.
REQ-023 For a read, mem_wren SHALL stay low throughout ACCESS.
REQ-024 mem_addr and mem_wdata SHALL be held constant for all of ACCESS.
REQ-025 On the last ACCESS clock edge:
- the FSM SHALL enter DONE;
- for a read, rdata SHALL capture mem_rdata;
- for a write, rdata SHALL remain unchanged.
REQ-026 DONE SHALL last one cycle. In it, ack[grant_id] SHALL be high, and the FSM SHALL then return to IDLE.
REQ-027 Grant-to-ack latency: a grant evaluated in IDLE cycle t SHALL give ACCESS cycles t+1 .. t+2*ACCESS_CYCLES and ack in cycle t+2*ACCESS_CYCLES+1.
REQ-028 The earliest next grant SHALL be the IDLE cycle after ack, giving a throughput of 1 access per 2*ACCESS_CYCLES+2 clocks.
REQ-029 A req dropped during ACCESS SHALL NOT abort the access; the ack SHALL still pulse.
REQ-030 A req change in IDLE SHALL take effect only at the next grant decision.
REQ-031 req, we, addr and wdata SHALL be ignored outside the IDLE sample point.
REQ-032 At most one ack SHALL be high in any cycle, and ack SHALL never be high outside DONE.
REQ-033 The counter SHALL be at least clog2(2*ACCESS_CYCLES+1) bits wide and SHALL NOT wrap; it is loaded only at grant.
REQ-034 mem_wren SHALL be low in IDLE and DONE.
REQ-035 mem_addr and mem_wdata SHALL hold their last values outside ACCESS.

Reset
REQ-036 The following SHALL reset to 0: ack0, ack1, rdata, mem_wren, mem_addr, mem_wdata, busy, grant_id and the counter.
REQ-037 last_grant SHALL reset to 1, so requester 0 wins the first tie.
REQ-038 Reset asserted mid-ACCESS or in DONE SHALL abort the access:
- no ack SHALL be issued;
- mem_wren SHALL be low from the cycle after reset is sampled;
- the FSM SHALL be in IDLE after reset is released.

Verification
REQ-039 Single read, default parameters: req0=1, we0=0, addr0=0x00010, mem_rdata=0xDEADBEEF -> mem_addr=0x00010 for 10 cycles, mem_wren=0 throughout, ack0 in cycle 11 after grant, rdata=0xDEADBEEF.
REQ-040 Single write: req1=1, we1=1, addr1=0x3FFFF, wdata1=0x80F02040 -> mem_wren=1 for exactly 5 cycles then 0 for 5, mem_wdata=0x80F02040 held, ack1 only, rdata unchanged.
REQ-041 Tie after reset: req0=req1=1 held -> grants alternate 0,1,0,1, with acks 12 cycles apart and never both high in one cycle.
REQ-042 Request drop: req0 deasserted in ACCESS cycle 3 -> access completes, ack0 still pulses in cycle 11.
REQ-043 Reset mid-operation: reset in ACCESS cycle 4 of a write -> mem_wren=0 the next cycle, no ack, busy=0; a subsequent req1 is granted normally.
REQ-044 Parameter sweep: ACCESS_CYCLES=3 -> ACCESS lasts 6 cycles, mem_wren high 3 cycles on writes, ack in cycle 7 after grant.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a multi-cycle SRAM controller.
// One access at a time: IDLE -> ACCESS (2*ACCESS_CYCLES clocks) -> DONE (ack) -> IDLE.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 5,
  parameter int ADDR_W        = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [31:0]       rdata,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  localparam int               CNT_W      = $clog2(2 * ACCESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(2 * ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_WR_END = CNT_W'(ACCESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_grant_q;
  logic               wr_q;
  logic               ack0_q;
  logic               ack1_q;
  logic [31:0]        rdata_q;
  logic               mem_wren_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [31:0]        mem_wdata_q;
  logic               busy_q;
  logic               grant_id_q;

  logic               any_req_d;
  logic               winner_d;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    any_req_d = req0 | req1;
    winner_d  = (req0 & req1) ? ~last_grant_q : req1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      wr_q         <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata_q      <= '0;
      mem_wren_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      grant_id_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack0_q     <= 1'b0;
          ack1_q     <= 1'b0;
          mem_wren_q <= 1'b0;
          if (any_req_d) begin
            state_q      <= ACCESS;
            busy_q       <= 1'b1;
            grant_id_q   <= winner_d;
            last_grant_q <= winner_d;
            cnt_q        <= CNT_LOAD;
            wr_q         <= winner_d ? we1 : we0;
            mem_wren_q   <= winner_d ? we1 : we0;
            mem_addr_q   <= winner_d ? addr1 : addr0;
            mem_wdata_q  <= winner_d ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q - CNT_LAST;
          // Write strobe covers only the first half so the controller samples it once.
          if (cnt_q == CNT_WR_END) begin
            mem_wren_q <= 1'b0;
          end
          if (cnt_q == CNT_LAST) begin
            state_q    <= DONE;
            mem_wren_q <= 1'b0;
            ack0_q     <= ~grant_id_q;
            ack1_q     <= grant_id_q;
            if (!wr_q) begin
              rdata_q <= mem_rdata;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign mem_wren  = mem_wren_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;

endmodule
